sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//   Shares the single-ported base-SRAM controller between the instruction-fetch (IF) and data-memory (DM) ports.
//   Sequences each access over WAIT_CYCLES strobe cycles and returns a one-cycle ack with read data.
//   Sits between the pipeline MEM/IF stages and the SRAM controller; drives the pipeline stall.
// PARAMETERS
//   WAIT_CYCLES  2   cycles strobes are held per access (>=1); covers taa=10ns / taw=8ns at core clock
//   ADDR_W       22  byte-address width of both requester ports and the controller port
// PORTS
//   clk        in   1       core clock, all state on rising edge
//   rst        in   1       asynchronous, active-high reset
//   if_req     in   1       IF read request; held with if_addr until if_ack
//   if_addr    in   ADDR_W  IF byte address (word aligned)
//   if_rdata   out  32      IF read data, valid while if_ack=1
//   if_ack     out  1       one-cycle completion pulse for IF
//   dm_req     in   1       DM request; held with dm_we/dm_byte/dm_addr/dm_wdata until dm_ack
//   dm_we      in   1       1=write, 0=read
//   dm_byte    in   1       1=byte access, 0=word access
//   dm_addr    in   ADDR_W  DM byte address
//   dm_wdata   in   32      DM write data (byte in [7:0] when dm_byte)
//   dm_rdata   out  32      DM read data, valid while dm_ack=1
//   dm_ack     out  1       one-cycle completion pulse for DM
//   mem_addr   out  ADDR_W  address to SRAM controller
//   mem_din    out  32      write data to controller
//   mem_dout   in   32      read data from controller
//   mem_ce_n   out  1       controller chip enable, active low
//   mem_oe_n   out  1       controller read enable, active low
//   mem_we_n   out  1       controller write enable, active low
//   mem_wb     out  1       byte-access flag to controller
//   stall      out  1       pipeline stall = (if_req&~if_ack)|(dm_req&~dm_ack)
// BEHAVIOUR
//   - Reset: state IDLE; mem_ce_n/oe_n/we_n=1; mem_addr=0; mem_din=0; mem_wb=0; acks=0; rdata=0; counter=0.
//   - Reset mid-access aborts immediately (async); no ack issued; strobes go inactive in the reset cycle.
//   - FSM: IDLE -> GRANT_IF | GRANT_DM -> IDLE. No other states.
//   - IDLE: if any req, latch grant, address, data, wb; enter GRANT_*, set counter=WAIT_CYCLES-1.
//   - GRANT_*: ce_n=0; oe_n=0 for read, we_n=0 for write (never both low); counter decrements each cycle.
//   - Counter==0 in GRANT_*: capture mem_dout into granted rdata, pulse granted ack, drop strobes, go IDLE.
//   - Latency: req seen at edge t -> strobes low from t+1 -> ack high in cycle t+WAIT_CYCLES.
//   - Back-to-back: one IDLE cycle between accesses; strobes high for that cycle.
//   - Simultaneous if_req & dm_req in IDLE: DM wins; IF waits; stall stays high.
//   - IF port: always read, word (mem_wb=0). DM port: dm_we/dm_byte forwarded unchanged.
//   - Req dropped mid-access: access completes and ack still pulses; requester ignores it.
//   - Ungranted port: ack=0; its rdata holds its last value.
//   - Counter width $clog2(WAIT_CYCLES+1); no wrap, reloaded only in IDLE.
// CONFIGURATION
//   SRAM_ARB_RR_EN defined: round-robin. On a tie, grant goes to the port not served last.
//     last_grant resets to DM, so the first tie goes to IF.
//   Undefined: fixed priority, DM over IF (the default above).
// STRUCTURE
//   sram_arb_pkg: FSM state encoding (IDLE/GRANT_IF/GRANT_DM), GRANT_IF/GRANT_DM constants, default WAIT_CYCLES.
//   One sub-module: sram_wait_timer (load/decrement counter, outputs zero flag).
// TESTING
//   1. WAIT_CYCLES=2, if_req addr 0x000100, mem_dout=0xDEADBEEF -> ce_n/oe_n low 2 cycles; if_ack once; if_rdata=0xDEADBEEF.
//   2. dm_req write, byte, addr 0x000203, wdata 0x55 -> we_n low 2 cycles, oe_n=1, mem_wb=1; mem_addr=0x000203; dm_ack once.
//   3. if_req & dm_req same edge -> DM served first, IF served next; stall=1 until if_ack; one IDLE cycle between.
//   4. With SRAM_ARB_RR_EN, both requesters held continuously -> grants alternate IF, DM, IF, DM.
//   5. rst pulsed mid GRANT_DM -> strobes high at once, no dm_ack; after release a new req completes normally.
//   6. Without SRAM_ARB_RR_EN, both requesters held continuously -> IF starves; assert oe_n&we_n never both low.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the IF/DM SRAM bus arbiter.
// Holds the FSM encoding, grant identifiers and the default wait-state count.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GRANT_IF = 2'd1,
        S_GRANT_DM = 2'd2
    } state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    // Two strobe cycles cover taa=10ns / taw=8ns at the core clock.
    localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_wait_timer.sv
// Wait-state down-counter: loads a start value, decrements to zero and holds there.
// Latency: zero flag follows the count register combinationally; no backpressure.
module sram_wait_timer #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = $clog2(WAIT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at zero; only a fresh load moves it away again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM controller between IF (read-only) and DM ports; DM wins ties unless SRAM_ARB_RR_EN.
// Latency: strobes low WAIT_CYCLES cycles after grant, then a one-cycle ack; stall holds pipeline until ack.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int ADDR_W      = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic              dm_byte,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              mem_wb,
    output logic              stall
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_tie_dm;
    logic                w_done;
    logic                w_zero;
    logic                w_load;
    logic                w_dec;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_din;
    logic                r_ce_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic                r_wb;
    logic                r_if_ack;
    logic                r_dm_ack;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_dm_rdata;

`ifdef SRAM_ARB_RR_EN
    logic                r_last_grant;

    // Resets to DM so the first contested grant goes to IF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GRANT_DM;
        end else if (w_state_nxt == S_GRANT_DM && r_state == S_IDLE) begin
            r_last_grant <= GRANT_DM;
        end else if (w_state_nxt == S_GRANT_IF && r_state == S_IDLE) begin
            r_last_grant <= GRANT_IF;
        end
    end

    assign w_tie_dm = (r_last_grant == GRANT_IF);
`else
    assign w_tie_dm = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dm_req && (!if_req || w_tie_dm)) begin
                    w_state_nxt = S_GRANT_DM;
                end else if (if_req) begin
                    w_state_nxt = S_GRANT_IF;
                end
            end
            S_GRANT_IF, S_GRANT_DM: begin
                if (w_zero) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_load = (r_state == S_IDLE) && (if_req || dm_req);
    assign w_dec  = (r_state != S_IDLE);

    sram_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    // Strobes are registered so they rise in the same edge that ends the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_wb       <= 1'b0;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_state_nxt == S_GRANT_DM) begin
                    r_mem_addr <= dm_addr;
                    r_mem_din  <= dm_wdata;
                    r_wb       <= dm_byte;
                    r_ce_n     <= 1'b0;
                    r_oe_n     <= dm_we;
                    r_we_n     <= ~dm_we;
                end else if (w_state_nxt == S_GRANT_IF) begin
                    r_mem_addr <= if_addr;
                    r_wb       <= 1'b0;
                    r_ce_n     <= 1'b0;
                    r_oe_n     <= 1'b0;
                    r_we_n     <= 1'b1;
                end
            end else if (w_done) begin
                r_ce_n <= 1'b1;
                r_oe_n <= 1'b1;
                r_we_n <= 1'b1;
                if (r_state == S_GRANT_IF) begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= mem_dout;
                end else begin
                    r_dm_ack   <= 1'b1;
                    r_dm_rdata <= mem_dout;
                end
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_ce_n = r_ce_n;
    assign mem_oe_n = r_oe_n;
    assign mem_we_n = r_we_n;
    assign mem_wb   = r_wb;
    assign if_ack   = r_if_ack;
    assign dm_ack   = r_dm_ack;
    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;
    assign stall    = (if_req & ~r_if_ack) | (dm_req & ~r_dm_ack);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with WAIT_CYCLES=2; RR or fixed-priority checks follow SRAM_ARB_RR_EN.
module tb_sram_bus_arbiter;

    localparam int ADDR_W = 22;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              dm_req;
    logic              dm_we;
    logic              dm_byte;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;
    logic              mem_ce_n;
    logic              mem_oe_n;
    logic              mem_we_n;
    logic              mem_wb;
    logic              stall;

    int tests = 0;
    int fails = 0;

    sram_bus_arbiter #(
        .WAIT_CYCLES (2),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_byte  (dm_byte),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_ce_n (mem_ce_n),
        .mem_oe_n (mem_oe_n),
        .mem_we_n (mem_we_n),
        .mem_wb   (mem_wb),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_if_ack;
        int n_dm_ack;
        int n_both_low;
        int n_stall_low;
        logic [3:0] seq;

        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_byte  = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        mem_dout = '0;
        tick();
        tick();
        check("rst_ce_n",  32'(mem_ce_n), 32'd1);
        check("rst_oe_n",  32'(mem_oe_n), 32'd1);
        check("rst_we_n",  32'(mem_we_n), 32'd1);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_din",   mem_din, 32'd0);
        check("rst_acks",  32'({if_ack, dm_ack, mem_wb}), 32'd0);
        check("rst_rdata", if_rdata | dm_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // DM byte write
        dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b1;
        dm_addr = 22'h000203; dm_wdata = 32'h0000_0055;
        mem_dout = 32'h0BAD_0BAD;
        tick();
        check("wr_c1_strb", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b010);
        check("wr_c1_wb",   32'(mem_wb), 32'd1);
        check("wr_c1_addr", 32'(mem_addr), 32'h000203);
        check("wr_c1_din",  mem_din, 32'h55);
        check("wr_c1_ack",  32'({dm_ack, stall}), 32'b01);
        tick();
        check("wr_c2_strb", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b010);
        check("wr_c2_ack",  32'(dm_ack), 32'd0);
        tick();
        check("wr_ack",     32'({dm_ack, stall}), 32'b10);
        check("wr_ack_strb", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b111);
        dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0;
        tick();
        check("wr_ack_pulse", 32'(dm_ack), 32'd0);

        // IF word read
        if_req = 1'b1; if_addr = 22'h000100;
        mem_dout = 32'hDEAD_BEEF;
        tick();
        check("if_c1_strb", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b001);
        check("if_c1_addr", 32'(mem_addr), 32'h000100);
        check("if_c1_wb",   32'(mem_wb), 32'd0);
        check("if_c1_stall", 32'({if_ack, stall}), 32'b01);
        tick();
        check("if_c2_strb", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b001);
        tick();
        check("if_ack",     32'({if_ack, stall, mem_ce_n, mem_oe_n}), 32'b1011);
        check("if_rdata",   if_rdata, 32'hDEAD_BEEF);
        if_req = 1'b0;
        tick();
        check("if_ack_pulse", 32'(if_ack), 32'd0);
        check("if_rdata_hold", if_rdata, 32'hDEAD_BEEF);

        // Simultaneous requests: DM first, one idle cycle, then IF
        if_req = 1'b1; if_addr = 22'h000104;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 22'h000400;
        mem_dout = 32'h1111_2222;
        tick();
        check("tie_c1_addr", 32'(mem_addr), 32'h000400);
        check("tie_c1_stall", 32'(stall), 32'd1);
        tick();
        tick();
        check("tie_dm_ack", 32'({dm_ack, if_ack}), 32'b10);
        check("tie_dm_rdata", dm_rdata, 32'h1111_2222);
        check("tie_idle_strb", 32'({mem_ce_n, stall}), 32'b11);
        dm_req = 1'b0;
        mem_dout = 32'hCAFE_F00D;
        tick();
        check("tie_if_addr", 32'(mem_addr), 32'h000104);
        check("tie_if_strb", 32'({mem_ce_n, mem_oe_n, stall}), 32'b001);
        tick();
        tick();
        check("tie_if_ack", 32'({if_ack, dm_ack, stall}), 32'b100);
        check("tie_if_rdata", if_rdata, 32'hCAFE_F00D);
        check("tie_dm_hold", dm_rdata, 32'h1111_2222);
        if_req = 1'b0;
        tick();

        // Reset in the middle of a DM read
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 22'h000800;
        mem_dout = 32'h3C3C_A5A5;
        tick();
        check("rst5_grant", 32'(mem_ce_n), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rst5_strb", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b111);
        check("rst5_addr", 32'(mem_addr), 32'd0);
        tick();
        check("rst5_noack", 32'(dm_ack), 32'd0);
        rst = 1'b0;
        tick();
        check("rst5_restart", 32'({mem_ce_n, mem_oe_n, dm_ack}), 32'b000);
        tick();
        check("rst5_c2", 32'(dm_ack), 32'd0);
        tick();
        check("rst5_ack", 32'(dm_ack), 32'd1);
        check("rst5_rdata", dm_rdata, 32'h3C3C_A5A5);
        dm_req = 1'b0;
        tick();

        // Both requesters held continuously
        n_if_ack = 0; n_dm_ack = 0; n_both_low = 0; n_stall_low = 0; seq = '0;
        if_req = 1'b1; if_addr = 22'h000200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 22'h000300;
`ifdef SRAM_ARB_RR_EN
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!mem_oe_n && !mem_we_n) n_both_low++;
            if (if_ack || dm_ack) seq = {seq[2:0], dm_ack};
            if (if_ack) n_if_ack++;
            if (dm_ack) n_dm_ack++;
        end
        check("rr_seq", 32'(seq), 32'b0101);
        check("rr_if_acks", 32'(n_if_ack), 32'd2);
        check("rr_dm_acks", 32'(n_dm_ack), 32'd2);
        check("rr_both_low", 32'(n_both_low), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!mem_oe_n && !mem_we_n) n_both_low++;
            if (!stall) n_stall_low++;
            if (if_ack) n_if_ack++;
            if (dm_ack) n_dm_ack++;
        end
        check("fp_if_starve", 32'(n_if_ack), 32'd0);
        check("fp_dm_acks", 32'(n_dm_ack), 32'd6);
        check("fp_both_low", 32'(n_both_low), 32'd0);
        check("fp_stall", 32'(n_stall_low), 32'd0);
`endif
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
